// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence detector: IDLE/RUN/DONE run control, overlapping match count.
// Optional bit-count abort is built only when SEQ_DET_TIMEOUT_EN is defined.
module seq_det_ctrl #(
    parameter int PAT_W   = 4,
    parameter int LEN_W   = 3,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             stop,
    input  logic             inp_valid,
    input  logic             inp,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done,
    output logic             timeout
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    // Only the newest PAT_W-1 bits need storing; the incoming bit completes the window.
    logic [PAT_W-2:0] sh;
    logic [PAT_W-1:0] sh_nxt, pat_r, mask;
    logic [LEN_W-1:0] len_r, eff_len, fill, fill_nxt;
    logic [CNT_W-1:0] tgt_r, cnt_r, cnt_inc;
    logic             match_r;
    logic             start_go, shift_en, hit, tgt_hit, to_hit;

    generate
        if (PAT_W < 2 || (1 << LEN_W) <= PAT_W || TIMEOUT < 1) begin : g_bad_params
            $error("seq_det_ctrl: illegal parameter combination");
        end
    endgenerate

    assign start_go = start && (state != RUN);
    assign shift_en = inp_valid && (state == RUN);
    assign sh_nxt   = {sh, inp};
    assign fill_nxt = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
    assign eff_len  = (len_r == '0)             ? LEN_W'(1)     :
                      (len_r > LEN_W'(PAT_W))   ? LEN_W'(PAT_W) : len_r;
    assign cnt_inc  = (&cnt_r) ? cnt_r : cnt_r + CNT_W'(1);

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) mask[i] = (LEN_W'(i) < eff_len);
    end

    assign hit     = shift_en && (((sh_nxt ^ pat_r) & mask) == '0) && (fill_nxt >= eff_len);
    assign tgt_hit = hit && (tgt_r != '0) && (cnt_inc == tgt_r);

`ifdef SEQ_DET_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] tcnt;
    logic            to_r;

    // A match on the final allowed bit resets the count instead of aborting.
    assign to_hit  = shift_en && !hit && (tcnt == TO_W'(TIMEOUT - 1));
    assign timeout = to_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
            to_r <= 1'b0;
        end else if (start_go) begin
            tcnt <= '0;
            to_r <= 1'b0;
        end else if (shift_en) begin
            tcnt <= hit ? '0 : tcnt + TO_W'(1);
            if (to_hit) to_r <= 1'b1;
        end
    end
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (tgt_hit || stop || to_hit) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh      <= '0;
            fill    <= '0;
            cnt_r   <= '0;
            match_r <= 1'b0;
            pat_r   <= '0;
            len_r   <= '0;
            tgt_r   <= '0;
        end else begin
            match_r <= hit;
            if (start_go) begin
                sh    <= '0;
                fill  <= '0;
                cnt_r <= '0;
            end else if (shift_en) begin
                sh   <= sh_nxt[PAT_W-2:0];
                fill <= fill_nxt;
                if (hit) cnt_r <= cnt_inc;
            end
            // Config is frozen while running and on the cycle a run is launched.
            if (cfg_we && (state != RUN) && !start) begin
                pat_r <= cfg_pat;
                len_r <= cfg_len;
                tgt_r <= cfg_target;
            end
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign match     = match_r;
    assign match_cnt = cnt_r;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: directed scenarios plus random traffic vs a bit-history model.
module tb_seq_det_ctrl;
    localparam int PAT_W = 4, LEN_W = 3, CNT_W = 8, TO = 8;

    logic             clk = 1'b0, rst = 1'b1;
    logic             cfg_we = 0, start = 0, stop = 0, inp_valid = 0, inp = 0;
    logic [PAT_W-1:0] cfg_pat = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic [CNT_W-1:0] cfg_target = '0;
    logic             busy, match, done, timeout;
    logic [CNT_W-1:0] match_cnt;

    seq_det_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_target(cfg_target), .start(start), .stop(stop), .inp_valid(inp_valid),
        .inp(inp), .busy(busy), .match(match), .match_cnt(match_cnt), .done(done),
        .timeout(timeout));

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // Reference model: history of qualified bits since start, plus run flags.
    bit   hist[$];
    int   expq[$];
    bit   m_run = 0, m_done = 0, m_to = 0;
    int   m_cnt = 0, m_tc = 0;
    logic [PAT_W-1:0] m_pat = '0;
    int   m_len = 0, m_tgt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(input bit v, input bit b, input bit st, input bit sp, input bit we);
        int  l;
        bit  hit, fin;
        if (!m_run) begin
            if (we && !st) begin m_pat = cfg_pat; m_len = cfg_len; m_tgt = cfg_target; end
            if (st) begin
                m_run = 1; m_done = 0; m_to = 0; m_cnt = 0; m_tc = 0;
                hist.delete();
            end
        end else begin
            fin = sp;
            if (v) begin
                hist.push_back(b);
                if (hist.size() > PAT_W) void'(hist.pop_front());
                l = (m_len == 0) ? 1 : (m_len > PAT_W) ? PAT_W : m_len;
                hit = (hist.size() >= l);
                for (int i = 0; i < l && hit; i++)
                    if (hist[hist.size() - 1 - i] != m_pat[i]) hit = 0;
                if (hit) begin
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                    expq.push_back(m_cnt);
                    if (m_tgt != 0 && m_cnt == m_tgt) fin = 1;
                    m_tc = 0;
                end else begin
                    m_tc++;
`ifdef SEQ_DET_TIMEOUT_EN
                    if (m_tc == TO) begin fin = 1; m_to = 1; end
`endif
                end
            end
            if (fin) begin m_run = 0; m_done = 1; end
        end
    endfunction

    task automatic check_levels();
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("match_cnt", match_cnt, m_cnt);
        chk("timeout", timeout, m_to);
    endtask

    task automatic cyc(input bit v, input bit b, input bit st, input bit sp, input bit we);
        inp_valid = v; inp = b; start = st; stop = sp; cfg_we = we;
        @(posedge clk);
        model_step(v, b, st, sp, we);
        #1;
        check_levels();
    endtask

    task automatic cfg(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic [CNT_W-1:0] t);
        cfg_pat = p; cfg_len = l; cfg_target = t;
        cyc(0, 0, 0, 0, 1);
    endtask

    task automatic send(input logic [15:0] s, input int n, input bit gaps);
        logic [15:0] w;
        w = s;
        for (int i = n - 1; i >= 0; i--) begin
            if (gaps) cyc(0, 0, 0, 0, 0);
            cyc(1, w[i], 0, 0, 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        m_run = 0; m_done = 0; m_to = 0; m_cnt = 0; m_tc = 0;
        m_pat = '0; m_len = 0; m_tgt = 0;
        expq.delete(); hist.delete();
        #1;
        check_levels();
        chk("match_in_reset", match, 0);
        #1 rst = 0;
    endtask

    // Monitor: every match pulse must correspond to the oldest expected match.
    always @(negedge clk) begin
        if (!rst) begin
            if (match) begin
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL match_spurious: got 1 expected 0 at %0t", $time);
                end else begin
                    chk("match_cnt_at_pulse", match_cnt, expq.pop_front());
                end
            end else if (expq.size() != 0) begin
                total++; bad++;
                $display("FAIL match_missing: got 0 expected 1 (cnt %0d) at %0t", expq.pop_front(), $time);
            end
        end
    end

    initial begin
        #12;
        do_reset();

        // 1011011 with overlap, no target; mid-run config write must be dropped.
        cfg(4'b1011, 3'd4, 8'd0);
        cyc(0, 0, 1, 0, 0);
        send(16'b1011011, 7, 0);
        cfg_pat = 4'b0000; cfg_len = 3'd1;
        cyc(1, 0, 0, 0, 1);
        send(16'b11, 2, 0);
        cyc(0, 0, 0, 1, 0);
        idle(2);

        // Target 2 ends the run after bit 7; later bits ignored. Config with start is ignored.
        cfg(4'b1011, 3'd4, 8'd2);
        cfg_pat = 4'b0000; cfg_target = 8'd9;
        cyc(0, 0, 1, 0, 1);
        send(16'b1011011011, 10, 0);
        idle(2);

        // Same stream with gaps.
        cyc(0, 0, 1, 0, 0);
        send(16'b1011011011, 10, 1);
        idle(2);

        // Short pattern 11.
        cfg(4'b0011, 3'd2, 8'd0);
        cyc(0, 0, 1, 0, 0);
        send(16'b111, 3, 0);
        cyc(0, 0, 0, 1, 0);

        // Stop coincident with the completing bit.
        cfg(4'b1011, 3'd4, 8'd0);
        cyc(0, 0, 1, 0, 0);
        send(16'b101, 3, 0);
        cyc(1, 1, 0, 1, 0);
        idle(2);

        // Async reset mid-run.
        cyc(0, 0, 1, 0, 0);
        send(16'b101, 3, 0);
        do_reset();
        idle(1);

        // Eight zeros: timeout when enabled, otherwise still running.
        cfg(4'b1011, 3'd4, 8'd0);
        cyc(0, 0, 1, 0, 0);
        send(16'b0, 8, 0);
        idle(2);
        cyc(0, 0, 0, 1, 0);

        // Length 0 acts as 1; count saturates; length above PAT_W clamps.
        cfg(4'b0001, 3'd0, 8'd0);
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 300; i++) cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cfg(4'b0110, 3'd7, 8'd0);
        cyc(0, 0, 1, 0, 0);
        send(16'b0110110, 7, 0);
        cyc(0, 0, 0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit we;
            we = ($urandom % 20 == 0);
            if (we) begin
                cfg_pat = PAT_W'($urandom); cfg_len = LEN_W'($urandom);
                cfg_target = CNT_W'($urandom % 4);
            end
            cyc(($urandom % 3) != 0, $urandom % 2, ($urandom % 25) == 0, ($urandom % 60) == 0, we);
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
